// File: rtl/axis_blank_pkg.sv
// Purpose: shared state encodings, widths and helpers for the blanking scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// DONE is not a separate encoding: it is IDLE with a sticky done flag, so the
// status port only ever shows the four values below.
package axis_blank_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ARMED = 2'd1;
    localparam logic [STATE_W-1:0] ST_BLANK = 2'd2;
    localparam logic [STATE_W-1:0] ST_PASS  = 2'd3;

    // A beat is replaced only in BLANK with a non-zero phase length; a
    // zero-length BLANK is skipped and must leave its cycle's beat untouched.
    function automatic logic substitute_beat(input state_t st, input logic len_zero);
        return (st == ST_BLANK) && !len_zero;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Purpose: one-entry AXI-stream output register (forward and ready path).
// Latency: 1 cycle from accept to m_vld_o.
// Backpressure: s_rdy_o = ~m_vld_o | m_rdy_i; held beat stable while stalled.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset (drops held beat)
//   s_dat_i/s_vld_i   - upstream data/valid; s_rdy_o upstream ready
//   m_dat_o/m_vld_o   - registered downstream data/valid; m_rdy_i downstream ready
module axis_reg_slice #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_vld_i,
    output logic              s_rdy_o,
    output logic [DATA_W-1:0] m_dat_o,
    output logic              m_vld_o,
    input  logic              m_rdy_i
);

    logic [DATA_W-1:0] dat_q;
    logic              vld_q;

    assign s_rdy_o = ~vld_q | m_rdy_i;
    assign m_dat_o = dat_q;
    assign m_vld_o = vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else if (s_vld_i && s_rdy_o) begin
            dat_q <= s_dat_i;
            vld_q <= 1'b1;
        end else if (m_rdy_i) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_blank_scheduler.sv
// Purpose: replaces blank_len beats with default_value, passes pass_len beats, repeats or stops.
// Latency: 1 cycle accept-to-output through the output register slice.
// Backpressure: s_axis_tready = ~m_axis_tvalid | m_axis_tready; nothing is dropped.
//
// Ports:
//   aclk, areset                 - clock, synchronous active-high reset
//   cfg_enable/cfg_trig_mode/cfg_continuous/cfg_blank_len/cfg_pass_len/default_value - config
//   trig                         - start pulse, honoured only in ARMED
//   s_axis_*                     - upstream stream; m_axis_* - downstream stream
//   sts_state, sts_cycles, done  - status: state, completed cycles, single-shot end pulse
module axis_blank_scheduler
    import axis_blank_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_enable,
    input  logic                        cfg_trig_mode,
    input  logic                        cfg_continuous,
    input  logic [CNTR_WIDTH-1:0]       cfg_blank_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_pass_len,
    input  logic [AXIS_TDATA_WIDTH-1:0] default_value,
    input  logic                        trig,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [STATE_W-1:0]          sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_cycles,
    output logic                        done
);

    state_t                  state_q, state_d;
    logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]   cycles_q, cycles_d;
    // Length of the phase currently running, captured on phase entry so that
    // config changes mid-phase only take effect at the next phase.
    logic [CNTR_WIDTH-1:0]   len_q, len_d;
    logic                    cont_q, cont_d;
    logic                    flag_q, flag_d;
    logic                    done_d;

    logic                    accept;
    logic                    len_zero;
    logic                    last_beat;
    logic [CNTR_WIDTH-1:0]   cnt_inc;
    logic [AXIS_TDATA_WIDTH-1:0] slice_dat;

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign len_zero  = (len_q == '0);
    assign cnt_inc   = cnt_q + CNTR_WIDTH'(1);
    assign last_beat = accept && (cnt_inc == len_q);

    // Substitution is decided as the beat enters the register; a held beat
    // is never rewritten.
    assign slice_dat = substitute_beat(state_q, len_zero) ? default_value : s_axis_tdata;

    axis_reg_slice #(
        .DATA_W (AXIS_TDATA_WIDTH)
    ) u_reg_slice (
        .clk     (aclk),
        .rst     (areset),
        .s_dat_i (slice_dat),
        .s_vld_i (s_axis_tvalid),
        .s_rdy_o (s_axis_tready),
        .m_dat_o (m_axis_tdata),
        .m_vld_o (m_axis_tvalid),
        .m_rdy_i (m_axis_tready)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        len_d    = len_q;
        cont_d   = cont_q;
        flag_d   = flag_q;
        done_d   = 1'b0;

        if (!cfg_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // flag_q set means DONE: wait for cfg_enable to drop.
                    if (!flag_q) begin
                        if (cfg_trig_mode) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_BLANK;
                            len_d   = cfg_blank_len;
                        end
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        state_d = ST_BLANK;
                        len_d   = cfg_blank_len;
                        cnt_d   = '0;
                    end
                end
                ST_BLANK: begin
                    // A zero-length phase exits without counting this cycle's beat.
                    if (len_zero || last_beat) begin
                        state_d = ST_PASS;
                        len_d   = cfg_pass_len;
                        cont_d  = cfg_continuous;
                        cnt_d   = '0;
                    end else if (accept) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin // ST_PASS
                    if (len_zero || last_beat) begin
                        cycles_d = cycles_q + CNTR_WIDTH'(1);
                        cnt_d    = '0;
                        if (cont_q) begin
                            state_d = ST_BLANK;
                            len_d   = cfg_blank_len;
                        end else begin
                            state_d = ST_IDLE;
                            flag_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else if (accept) begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cycles_q <= '0;
            len_q    <= '0;
            cont_q   <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            len_q    <= len_d;
            cont_q   <= cont_d;
            flag_q   <= flag_d;
        end
    end

    assign sts_state  = state_q;
    assign sts_cycles = cycles_q;
    // Pulse is asserted in the cycle the single-shot sequence completes; the
    // state leaves PASS on the following edge, so it lasts exactly one cycle.
    assign done       = done_d;

endmodule

// File: tb/tb_axis_blank_scheduler.sv
module tb_axis_blank_scheduler;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam logic [31:0] DV = 32'hDEAD_BEEF;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_enable, cfg_trig_mode, cfg_continuous;
    logic [CW-1:0] cfg_blank_len, cfg_pass_len;
    logic [DW-1:0] default_value;
    logic          trig;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
    logic [1:0]    sts_state;
    logic [CW-1:0] sts_cycles;
    logic          done;

    axis_blank_scheduler #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_enable(cfg_enable), .cfg_trig_mode(cfg_trig_mode), .cfg_continuous(cfg_continuous),
        .cfg_blank_len(cfg_blank_len), .cfg_pass_len(cfg_pass_len),
        .default_value(default_value), .trig(trig),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .sts_state(sts_state), .sts_cycles(sts_cycles), .done(done)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic        rdy_seen = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge aclk) begin
        rdy_seen = s_axis_tready;
        if (done === 1'b1) done_cnt++;
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got %0h required none", m_axis_tdata);
            end else begin
                check("beat_data", m_axis_tdata, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int k;
        k = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        exp_q.push_back(e);
        forever begin
            @(posedge aclk);
            if (rdy_seen) break;
            k++;
            if (k > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got no accept required accept of %0h", d);
                break;
            end
        end
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic restart(input logic tm, input logic cont, input int bl, input int pl);
        cfg_enable = 1'b0;
        @(posedge aclk); #1;
        cfg_trig_mode  = tm;
        cfg_continuous = cont;
        cfg_blank_len  = CW'(bl);
        cfg_pass_len   = CW'(pl);
        cfg_enable     = 1'b1;
        @(posedge aclk); #1;
    endtask

    int d0;
    int first_k;

    initial begin
        areset = 1'b1;
        cfg_enable = 1'b0; cfg_trig_mode = 1'b0; cfg_continuous = 1'b0;
        cfg_blank_len = '0; cfg_pass_len = '0;
        default_value = DV; trig = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_s_tready", s_axis_tready, 1);
        check("rst_state", sts_state, 0);
        check("rst_cycles", sts_cycles, 0);
        check("rst_done", done, 0);

        // Single shot, blank 3, pass 2: D,D,D,4,5 then unchanged
        @(posedge aclk); #1;
        d0 = done_cnt;
        restart(1'b0, 1'b0, 3, 2);
        @(negedge aclk);
        check("t1_state_blank", sts_state, 2);
        @(posedge aclk); #1;
        send(1, DV); send(2, DV); send(3, DV); send(4, 4); send(5, 5);
        send(6, 6); send(7, 7);
        trig = 1'b1;                      // must be ignored in DONE
        @(posedge aclk); #1 trig = 1'b0;
        @(negedge aclk);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_cycles", sts_cycles, 1);
        check("t1_state_done", sts_state, 0);

        // Continuous, blank 1, pass 1: D,2,D,4
        restart(1'b0, 1'b1, 1, 1);
        send(1, DV); send(2, 2);
        @(negedge aclk);
        check("t2_cycles_mid", sts_cycles, 2);
        @(posedge aclk); #1;
        send(3, DV); send(4, 4);
        @(negedge aclk);
        check("t2_cycles_end", sts_cycles, 3);
        check("t2_state_blank", sts_state, 2);
        @(posedge aclk); #1;

        // Trig mode: 1..5 unchanged while armed, then D,D,8
        restart(1'b1, 1'b0, 2, 1);
        @(negedge aclk);
        check("t3_state_armed", sts_state, 1);
        @(posedge aclk); #1;
        for (int i = 1; i <= 5; i++) send(32'(i), 32'(i));
        trig = 1'b1;
        @(posedge aclk); #1 trig = 1'b0;
        send(6, DV); send(7, DV); send(8, 8);
        @(negedge aclk);
        check("t3_cycles", sts_cycles, 4);
        check("t3_state_done", sts_state, 0);
        @(posedge aclk); #1;

        // Backpressure while a D beat is held
        restart(1'b0, 1'b1, 2, 2);
        m_axis_tready = 1'b0;
        send(1, DV);
        fork
            begin
                send(2, DV); send(3, 3); send(4, 4);
            end
            begin
                repeat (4) begin
                    @(negedge aclk);
                    check("hold_m_tvalid", m_axis_tvalid, 1);
                    check("hold_m_tdata", m_axis_tdata, DV);
                    check("hold_s_tready", s_axis_tready, 0);
                end
                @(posedge aclk); #1 m_axis_tready = 1'b1;
            end
        join
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("t4_cycles", sts_cycles, 5);
        check("t4_state_blank", sts_state, 2);
        @(posedge aclk); #1;

        // Both lengths zero, single shot: done within 2 cycles, beats untouched
        d0 = done_cnt;
        first_k = -1;
        cfg_enable = 1'b0;
        @(posedge aclk); #1;
        cfg_trig_mode = 1'b0; cfg_continuous = 1'b0;
        cfg_blank_len = '0; cfg_pass_len = '0;
        cfg_enable = 1'b1;
        fork
            begin
                send(1, 1); send(2, 2); send(3, 3);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge aclk);
                    if (done === 1'b1 && first_k < 0) first_k = k;
                end
            end
        join
        check("t5_done_seen_cycle", first_k, 2);
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_cycles", sts_cycles, 6);
        check("t5_state_done", sts_state, 0);
        @(posedge aclk); #1;

        // Enable drop mid-BLANK, then reset while a beat is held
        restart(1'b0, 1'b1, 4, 1);
        send(1, DV); send(2, DV);
        cfg_enable = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("t6_state_idle", sts_state, 0);
        @(posedge aclk); #1;
        m_axis_tready = 1'b0;
        s_axis_tdata  = 32'h3;
        s_axis_tvalid = 1'b1;
        @(posedge aclk); #1 s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("t6_held_vld", m_axis_tvalid, 1);
        check("t6_held_dat", m_axis_tdata, 3);
        check("t6_held_s_tready", s_axis_tready, 0);
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("t6_rst_m_tvalid", m_axis_tvalid, 0);
        check("t6_rst_m_tdata", m_axis_tdata, 0);
        check("t6_rst_cycles", sts_cycles, 0);
        check("t6_rst_state", sts_state, 0);
        check("t6_rst_s_tready", s_axis_tready, 1);
        @(posedge aclk); #1 m_axis_tready = 1'b1;

        repeat (3) @(posedge aclk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
